// File: rtl/local_prediction_table.sv
// Local prediction table: a table of saturating direction counters indexed by
// a per-branch local history pattern. One branch is in flight at a time: a
// lookup returns the counter one cycle after acceptance, the resolved outcome
// trains that same counter, and only then is the next lookup accepted.
// Optional statistics counters are included when LPT_STATS_EN is defined.
module local_prediction_table #(
   parameter int unsigned HIST_W   = 10,
   parameter int unsigned CTR_W    = 3,
   parameter int unsigned CTR_INIT = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              lookup_valid,
   input  logic [HIST_W-1:0] lookup_hist,
   output logic              lookup_ready,
   output logic              pred_valid,
   output logic              pred_taken,
   output logic [CTR_W-1:0]  pred_ctr,
   input  logic              resolve_valid,
   input  logic              resolve_taken,
`ifdef LPT_STATS_EN
   output logic [15:0]       lookup_count,
   output logic [15:0]       mispredict_count,
`endif
   output logic              busy
);

   localparam int unsigned DEPTH = 2 ** HIST_W;
   localparam logic [CTR_W-1:0] CTR_MAX   = '1;
   localparam logic [CTR_W-1:0] CTR_RESET = CTR_W'(CTR_INIT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RESP,
      ST_WAIT,
      ST_WRITE
   } state_t;

   state_t             state_q, state_d;
   logic [HIST_W-1:0]  hist_q, hist_d;
   logic [CTR_W-1:0]   upd_q, upd_d;
   logic               pred_valid_q, pred_valid_d;
   logic               pred_taken_q, pred_taken_d;
   logic [CTR_W-1:0]   pred_ctr_q, pred_ctr_d;
   logic [CTR_W-1:0]   ctr_table_q [DEPTH];
   logic               lookup_accept;
   logic               resolve_accept;

   // Saturating increment on taken, saturating decrement on not-taken.
   function automatic logic [CTR_W-1:0] train(input logic [CTR_W-1:0] ctr,
                                              input logic             taken);
      if (taken) return (ctr == CTR_MAX) ? ctr : ctr + 1'b1;
      else       return (ctr == '0)      ? ctr : ctr - 1'b1;
   endfunction

   // Next-state and datapath control for the single in-flight branch.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d        = state_q;
      hist_d         = hist_q;
      upd_d          = upd_q;
      pred_valid_d   = 1'b0;
      pred_taken_d   = pred_taken_q;
      pred_ctr_d     = pred_ctr_q;
      lookup_accept  = 1'b0;
      resolve_accept = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (lookup_valid) begin
               lookup_accept = 1'b1;
               hist_d        = lookup_hist;
               pred_ctr_d    = ctr_table_q[lookup_hist];
               pred_taken_d  = ctr_table_q[lookup_hist][CTR_W-1];
               pred_valid_d  = 1'b1;
               state_d       = ST_RESP;
            end
         end
         ST_RESP, ST_WAIT: begin
            if (resolve_valid) begin
               resolve_accept = 1'b1;
               // Trains from the value captured at lookup, not a fresh read.
               upd_d          = train(pred_ctr_q, resolve_taken);
               state_d        = ST_WRITE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WRITE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Control and prediction registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         hist_q       <= '0;
         upd_q        <= '0;
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         pred_ctr_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q      <= state_d;
         hist_q       <= hist_d;
         upd_q        <= upd_d;
         pred_valid_q <= pred_valid_d;
         pred_taken_q <= pred_taken_d;
         pred_ctr_q   <= pred_ctr_d;
      end
   end

   // Counter table: written only in WRITE, so a reset mid-branch drops the update.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         // NOTE: the table must come up weakly not-taken, so this storage is
         // built from resettable flops rather than an unreset RAM.
         for (int i = 0; i < DEPTH; i++) ctr_table_q[i] <= CTR_RESET;
      end else if (state_q == ST_WRITE) begin
         ctr_table_q[hist_q] <= upd_q;
      end
   end

`ifdef LPT_STATS_EN
   logic [15:0] lookup_count_q, lookup_count_d;
   logic [15:0] mispredict_count_q, mispredict_count_d;

   // Saturating event counters for accepted lookups and mispredictions.
   always_comb begin
      lookup_count_d     = lookup_count_q;
      mispredict_count_d = mispredict_count_q;
      if (lookup_accept && lookup_count_q != 16'hFFFF)
         lookup_count_d = lookup_count_q + 16'd1;
      if (resolve_accept && (resolve_taken != pred_taken_q) &&
          mispredict_count_q != 16'hFFFF)
         mispredict_count_d = mispredict_count_q + 16'd1;
   end

   // Statistics registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lookup_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         lookup_count_q     <= lookup_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign lookup_count     = lookup_count_q;
   assign mispredict_count = mispredict_count_q;
`else
   logic unused_stats;
   assign unused_stats = resolve_accept;
`endif

   assign lookup_ready = (state_q == ST_IDLE);
   assign busy         = (state_q != ST_IDLE);
   assign pred_valid   = pred_valid_q;
   assign pred_taken   = pred_taken_q;
   assign pred_ctr     = pred_ctr_q;

endmodule

// File: tb/tb_local_prediction_table.sv
// Directed bench for local_prediction_table: counter saturation at both ends,
// index isolation, ignored lookups while busy, reset abort and (when
// LPT_STATS_EN is defined) the statistics counters.
module tb_local_prediction_table;

   logic       clock = 1'b0;
   logic       reset;
   logic       lookup_valid;
   logic [9:0] lookup_hist;
   logic       lookup_ready;
   logic       pred_valid;
   logic       pred_taken;
   logic [2:0] pred_ctr;
   logic       resolve_valid;
   logic       resolve_taken;
   logic       busy;
`ifdef LPT_STATS_EN
   logic [15:0] lookup_count;
   logic [15:0] mispredict_count;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   local_prediction_table dut (
      .clock         (clock),
      .reset         (reset),
      .lookup_valid  (lookup_valid),
      .lookup_hist   (lookup_hist),
      .lookup_ready  (lookup_ready),
      .pred_valid    (pred_valid),
      .pred_taken    (pred_taken),
      .pred_ctr      (pred_ctr),
      .resolve_valid (resolve_valid),
      .resolve_taken (resolve_taken),
`ifdef LPT_STATS_EN
      .lookup_count     (lookup_count),
      .mispredict_count (mispredict_count),
`endif
      .busy          (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Entered and left at a negedge with the DUT idle. Resolves after w WAIT
   // cycles (0 = resolve in RESP); poke drives lookup_valid during WAIT.
   task automatic run_branch(input string tag, input logic [9:0] h, input logic t,
                             input int w, input logic [2:0] exp, input logic poke);
      check({tag, " ready_idle"}, 32'(lookup_ready), 32'd1);
      lookup_valid = 1'b1;
      lookup_hist  = h;
      @(negedge clock);
      lookup_valid = 1'b0;
      check({tag, " pred_valid"}, 32'(pred_valid), 32'd1);
      check({tag, " pred_ctr"},   32'(pred_ctr),   32'(exp));
      check({tag, " pred_taken"}, 32'(pred_taken), 32'(exp[2]));
      check({tag, " ready_resp"}, 32'(lookup_ready), 32'd0);
      for (int i = 0; i < w; i++) begin
         @(negedge clock);
         check({tag, " wait_pv"},    32'(pred_valid),   32'd0);
         check({tag, " wait_ready"}, 32'(lookup_ready), 32'd0);
         lookup_valid = poke;
         lookup_hist  = 10'h155;
      end
      lookup_valid  = 1'b0;
      resolve_valid = 1'b1;
      resolve_taken = t;
      @(negedge clock);
      resolve_valid = 1'b0;
      check({tag, " write_busy"}, 32'(busy),         32'd1);
      check({tag, " write_ready"},32'(lookup_ready), 32'd0);
      @(negedge clock);
      check({tag, " idle_busy"},  32'(busy),       32'd0);
      check({tag, " hold_ctr"},   32'(pred_ctr),   32'(exp));
      check({tag, " hold_pv"},    32'(pred_valid), 32'd0);
   endtask

   initial begin
      logic [2:0] exp_up [7];
      logic [2:0] exp_dn [5];
      exp_up = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
      exp_dn = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};

      reset = 1'b1; lookup_valid = 1'b0; lookup_hist = '0;
      resolve_valid = 1'b0; resolve_taken = 1'b0;
      repeat (2) @(negedge clock);
      check("rst pred_valid", 32'(pred_valid), 32'd0);
      check("rst pred_taken", 32'(pred_taken), 32'd0);
      check("rst pred_ctr",   32'(pred_ctr),   32'd0);
      check("rst busy",       32'(busy),       32'd0);
      check("rst ready",      32'(lookup_ready), 32'd1);
      reset = 1'b0;
      @(negedge clock);

      // First lookup, resolved after one WAIT cycle: ready low for 3 cycles.
      run_branch("h000", 10'h000, 1'b0, 1, 3'd3, 1'b0);

      // Ceiling saturation.
      for (int i = 0; i < 7; i++)
         run_branch($sformatf("up%0d", i), 10'h155, 1'b1, 0, exp_up[i], 1'b0);

      // Floor saturation.
      for (int i = 0; i < 5; i++)
         run_branch($sformatf("dn%0d", i), 10'h3FF, 1'b0, 0, exp_dn[i], 1'b0);

      // Index isolation with lookups poked while busy, then confirm neighbours.
      run_branch("iso156", 10'h156, 1'b1, 3, 3'd3, 1'b1);
      run_branch("iso155", 10'h155, 1'b1, 0, 3'd7, 1'b0);
      run_branch("iso156b",10'h156, 1'b0, 0, 3'd4, 1'b0);
      run_branch("iso000", 10'h000, 1'b1, 0, 3'd2, 1'b0);

      // Reset while waiting on a resolve.
      lookup_valid = 1'b1;
      lookup_hist  = 10'h2AA;
      @(negedge clock);
      lookup_valid = 1'b0;
      repeat (10) @(negedge clock);
      check("wait busy", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("abort busy",  32'(busy),       32'd0);
      check("abort ctr",   32'(pred_ctr),   32'd0);
      check("abort taken", 32'(pred_taken), 32'd0);
      check("abort pv",    32'(pred_valid), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // Prediction/outcome pairs (0,1),(1,1),(1,0),(0,0).
      run_branch("st0", 10'h010, 1'b1, 0, 3'd3, 1'b0);
      run_branch("st1", 10'h010, 1'b1, 0, 3'd4, 1'b0);
      run_branch("st2", 10'h010, 1'b0, 0, 3'd5, 1'b0);
      run_branch("st3", 10'h020, 1'b0, 0, 3'd3, 1'b0);
`ifdef LPT_STATS_EN
      check("lookup_count",     32'(lookup_count),     32'd4);
      check("mispredict_count", 32'(mispredict_count), 32'd2);
`endif

      run_branch("after_abort", 10'h2AA, 1'b1, 0, 3'd3, 1'b0);
      run_branch("after_rst155",10'h155, 1'b0, 0, 3'd3, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
